// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding unit: stage 1 picks the increment and forms the
// rounded significand, stage 2 fixes up the exponent and packs the result with flags.
module fp_round_pipe #(
    parameter int EW = 11,
    parameter int FW = 52
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [2:0]      rm,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic            i_sign,
    input  logic [EW-1:0]   i_exp,
    input  logic [FW+3:0]   i_sig,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [EW+FW:0]  o,
    output logic            o_nx,
    output logic            o_of,
    output logic            o_uf
);

    logic            adv;

    logic            in_special;
    logic            in_inx;
    logic            in_rnd;
    logic            in_rod;
    logic [FW+1:0]   in_sum;

    logic            s1_valid;
    logic            s1_sign;
    logic            s1_special;
    logic [EW-1:0]   s1_exp;
    logic [FW+1:0]   s1_sum;
    logic            s1_carry;
    logic            s1_den;
    logic            s1_inx;
    logic            s1_rod;

    logic [EW-1:0]   r_exp;
    logic [FW-1:0]   r_frac;
    logic            r_nx;
    logic            r_of;
    logic            r_uf;

    assign adv     = ce & (~o_valid | o_ready);
    // Reset empties the output register, so the unit is ready whenever clocked.
    assign i_ready = ce & (rst | ~o_valid | o_ready);

    always_comb begin
        logic g, r, s, l;
        l          = i_sig[3];
        g          = i_sig[2];
        r          = i_sig[1];
        s          = i_sig[0];
        in_special = &i_exp;
        in_inx     = g | r | s;
        in_rod     = (rm == 3'b101);
        case (rm)
            3'b001:  in_rnd = 1'b0;
            3'b010:  in_rnd = in_inx & ~i_sign;
            3'b011:  in_rnd = in_inx & i_sign;
            3'b100:  in_rnd = g;
            3'b101:  in_rnd = 1'b0;
            default: in_rnd = (g & (r | s)) | (g & ~r & ~s & l);
        endcase
        if (in_special) begin
            in_rnd = 1'b0;
        end
        in_sum = {1'b0, i_sig[FW+3:3]} + {{(FW+1){1'b0}}, in_rnd};
    end

    always_comb begin
        r_exp  = s1_exp;
        r_frac = s1_sum[FW-1:0];
        r_of   = 1'b0;
        if (s1_special) begin
            r_exp = '1;
        end else if (s1_carry) begin
            r_exp  = s1_exp + 1'b1;
            r_frac = '0;
        end else if (s1_den && s1_sum[FW]) begin
            r_exp = {{(EW-1){1'b0}}, 1'b1};
        end
        if (!s1_special && s1_rod && s1_inx) begin
            r_frac[0] = 1'b1;
        end
        // Rounding carried the exponent into the Inf/NaN code: saturate to Inf.
        if (!s1_special && (&r_exp)) begin
            r_frac = '0;
            r_of   = 1'b1;
        end
        r_nx = ~s1_special & s1_inx;
        r_uf = ~s1_special & s1_inx & (r_exp == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            o_valid  <= 1'b0;
            o        <= '0;
            o_nx     <= 1'b0;
            o_of     <= 1'b0;
            o_uf     <= 1'b0;
        end else if (adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign    <= i_sign;
                s1_special <= in_special;
                s1_exp     <= i_exp;
                s1_sum     <= in_sum;
                s1_carry   <= in_sum[FW+1];
                s1_den     <= (i_exp == '0);
                s1_inx     <= in_inx & ~in_special;
                s1_rod     <= in_rod;
            end
            o_valid <= s1_valid;
            if (s1_valid) begin
                o    <= {s1_sign, r_exp, r_frac};
                o_nx <= r_nx;
                o_of <= r_of;
                o_uf <= r_uf;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed checks of fp_round_pipe in single precision: rounding modes,
// overflow, denormals, specials, backpressure, clock enable and reset.
module tb_fp_round_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [2:0]  rm;
    logic        i_valid;
    logic        i_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [26:0] i_sig;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o;
    logic        o_nx;
    logic        o_of;
    logic        o_uf;

    int n_chk = 0;
    int n_bad = 0;

    fp_round_pipe #(.EW(8), .FW(23)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rm(rm),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig),
        .o_valid(o_valid), .o_ready(o_ready),
        .o(o), .o_nx(o_nx), .o_of(o_of), .o_uf(o_uf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        if (obs !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    // Called #1 after a rising edge with an empty-or-draining pipe and o_ready high.
    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [26:0] sg, input logic [2:0] m,
                           input logic [31:0] eo, input logic [2:0] ef);
        i_sign  = s;
        i_exp   = e;
        i_sig   = sg;
        rm      = m;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        check_val({tag, "_v"}, 64'(o_valid), 64'(1'b1));
        check_val(tag, 64'(o), 64'(eo));
        check_val({tag, "_flg"}, 64'({o_nx, o_of, o_uf}), 64'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int got;
        logic [31:0] prev_o;

        rst = 1'b1; ce = 1'b1; rm = 3'b000; i_valid = 1'b0; i_sign = 1'b0;
        i_exp = '0; i_sig = '0; o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ovalid", 64'(o_valid), 64'(1'b0));
        check_val("rst_o", 64'(o), 64'(32'h0));
        check_val("rst_flg", 64'({o_nx, o_of, o_uf}), 64'(3'b000));
        check_val("rst_iready", 64'(i_ready), 64'(1'b1));
        rst = 1'b0;
        @(posedge clk); #1;

        // flag order {nx, of, uf}
        run_vec("rne_tie_odd",  1'b0, 8'h80, {1'b1, 23'h000001, 3'b100}, 3'b000, 32'h40000002, 3'b100);
        run_vec("rne_tie_even", 1'b0, 8'h80, {1'b1, 23'h000002, 3'b100}, 3'b000, 32'h40000002, 3'b100);
        run_vec("rm6_as_rne",   1'b0, 8'h80, {1'b1, 23'h000001, 3'b100}, 3'b110, 32'h40000002, 3'b100);
        run_vec("carry_exp",    1'b0, 8'h80, {1'b1, 23'h7FFFFF, 3'b100}, 3'b000, 32'h40800000, 3'b100);
        run_vec("ovf_rne",      1'b0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 3'b000, 32'h7F800000, 3'b110);
        run_vec("ovf_rtz",      1'b0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 3'b001, 32'h7F7FFFFF, 3'b100);
        run_vec("den_promote",  1'b0, 8'h00, {1'b0, 23'h7FFFFF, 3'b110}, 3'b000, 32'h00800000, 3'b100);
        run_vec("den_stay",     1'b0, 8'h00, {1'b0, 23'h7FFFFF, 3'b010}, 3'b001, 32'h007FFFFF, 3'b101);
        run_vec("mode_rup",     1'b1, 8'h7F, {1'b1, 23'h000000, 3'b010}, 3'b010, 32'hBF800000, 3'b100);
        run_vec("mode_rdn",     1'b1, 8'h7F, {1'b1, 23'h000000, 3'b010}, 3'b011, 32'hBF800001, 3'b100);
        run_vec("mode_rod",     1'b1, 8'h7F, {1'b1, 23'h000000, 3'b010}, 3'b101, 32'hBF800001, 3'b100);
        run_vec("mode_rmm",     1'b1, 8'h7F, {1'b1, 23'h000000, 3'b010}, 3'b100, 32'hBF800000, 3'b100);
        run_vec("mode_rne",     1'b1, 8'h7F, {1'b1, 23'h000000, 3'b010}, 3'b000, 32'hBF800000, 3'b100);
        run_vec("neg_zero",     1'b1, 8'h00, 27'h0,                      3'b000, 32'h80000000, 3'b000);
        for (int m = 0; m < 8; m++) begin
            run_vec($sformatf("special_rm%0d", m), 1'b0, 8'hFF, {1'b0, 23'h400001, 3'b111},
                    3'(m), 32'h7FC00001, 3'b000);
        end

        // ce low holds everything and blocks input
        ce = 1'b0; i_valid = 1'b1; i_exp = 8'h80; i_sig = {1'b1, 23'h000055, 3'b000}; rm = 3'b001;
        @(posedge clk); @(posedge clk); #1;
        check_val("ce_iready", 64'(i_ready), 64'(1'b0));
        check_val("ce_ovalid", 64'(o_valid), 64'(1'b1));
        check_val("ce_hold_o", 64'(o), 64'(32'h7FC00001));
        i_valid = 1'b0; ce = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_val("ce_no_beat", 64'(o_valid), 64'(1'b0));

        // 8-beat stream with a 3-cycle o_ready drop
        sent = 0; got = 0; prev_o = '0;
        i_sign = 1'b0; i_exp = 8'h80; rm = 3'b001;
        for (int c = 0; c < 40 && got < 8; c++) begin
            o_ready = !(c >= 5 && c < 8);
            if (sent < 8) begin
                i_valid = 1'b1;
                i_sig   = {1'b1, 23'(sent + 1), 3'b000};
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 5 && c < 8) begin
                check_val($sformatf("stall_iready_c%0d", c), 64'(i_ready), 64'(1'b0));
                check_val($sformatf("stall_ovalid_c%0d", c), 64'(o_valid), 64'(1'b1));
                if (c > 5) check_val($sformatf("stall_hold_c%0d", c), 64'(o), 64'(prev_o));
            end
            if (o_valid && o_ready) begin
                check_val($sformatf("stream_beat%0d", got), 64'(o), 64'(32'h40000000 | 32'(got + 1)));
                got++;
            end
            if (i_valid && i_ready) sent++;
            prev_o = o;
            @(posedge clk); #1;
        end
        i_valid = 1'b0; o_ready = 1'b1;
        check_val("stream_count", 64'(got), 64'(8));
        @(posedge clk); #1;
        check_val("stream_drained", 64'(o_valid), 64'(1'b0));

        // reset with two beats in flight
        i_valid = 1'b1; i_sig = {1'b1, 23'h000011, 3'b000};
        @(posedge clk); #1;
        i_sig = {1'b1, 23'h000022, 3'b000};
        @(posedge clk); #1;
        i_valid = 1'b0; rst = 1'b1;
        check_val("rst_iready_during", 64'(i_ready), 64'(1'b1));
        @(posedge clk); #1;
        check_val("rst_flush_ovalid", 64'(o_valid), 64'(1'b0));
        check_val("rst_flush_o", 64'(o), 64'(32'h0));
        rst = 1'b0;
        i_valid = 1'b1; i_sig = {1'b1, 23'h000033, 3'b000};
        @(posedge clk); #1;
        i_valid = 1'b0;
        check_val("rst_no_ghost", 64'(o_valid), 64'(1'b0));
        @(posedge clk); #1;
        check_val("post_rst_v", 64'(o_valid), 64'(1'b1));
        check_val("post_rst_o", 64'(o), 64'(32'h40000033));
        @(posedge clk); #1;
        check_val("post_rst_single", 64'(o_valid), 64'(1'b0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
